// File: rtl/pocket_video_pkg.sv
// Shared timing defaults, pixel type and colour-bar table for the Pocket video timing generator.
// The colour-bar helper is only referenced when VIDGEN_TESTPATTERN_EN is defined.
package pocket_video_pkg;

  localparam int H_ACTIVE_DEF     = 400;
  localparam int H_TOTAL_DEF      = 560;
  localparam int H_HS_START_DEF   = 450;
  localparam int V_ACTIVE_DEF     = 360;
  localparam int V_TOTAL_DEF      = 420;
  localparam int V_VS_LINE_DEF    = 380;
  localparam int READ_LATENCY_DEF = 2;

  localparam int BAR_WIDTH = 50;

  typedef logic [23:0] rgb888_t;

  localparam rgb888_t BAR_COLOURS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Columns beyond the eighth bar stay black.
  function automatic rgb888_t bar_colour(input logic [8:0] x);
    logic [8:0] idx;
    idx = x / 9'(BAR_WIDTH);
    if (idx > 9'd7) idx = 9'd7;
    return BAR_COLOURS[idx[2:0]];
  endfunction

endpackage

// File: rtl/pocket_video_timing_gen_if.sv
// Pixel-fetch and scaler video bus of the timing generator (master = generator side).
// tp_sel exists only when VIDGEN_TESTPATTERN_EN is defined.
interface pocket_video_timing_gen_if;
  import pocket_video_pkg::*;

  logic       en;
  logic       px_req;
  logic [8:0] px_x;
  logic [8:0] px_y;
  rgb888_t    px_data;
  logic       vid_de;
  logic       vid_hs;
  logic       vid_vs;
  rgb888_t    vid_rgb;
  logic       frame_start;
  logic       busy;
`ifdef VIDGEN_TESTPATTERN_EN
  logic       tp_sel;

  modport master (
    input  en, px_data, tp_sel,
    output px_req, px_x, px_y, vid_de, vid_hs, vid_vs, vid_rgb, frame_start, busy
  );
  modport slave (
    output en, px_data, tp_sel,
    input  px_req, px_x, px_y, vid_de, vid_hs, vid_vs, vid_rgb, frame_start, busy
  );
`else
  modport master (
    input  en, px_data,
    output px_req, px_x, px_y, vid_de, vid_hs, vid_vs, vid_rgb, frame_start, busy
  );
  modport slave (
    output en, px_data,
    input  px_req, px_x, px_y, vid_de, vid_hs, vid_vs, vid_rgb, frame_start, busy
  );
`endif

endinterface

// File: rtl/pocket_video_timing_gen_delay.sv
// Fixed-depth shift register used to align sync/DE (and test-pattern column) with returned pixel data.
// It always shifts so in-flight values drain out after the generator stops.
module pocket_video_delay #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 3
) (
  input  logic             clk_vid,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/pocket_video_timing_gen.sv
// Raster counters, pixel-fetch requests and DE/HS/VS/RGB output for the Pocket scaler.
// Define VIDGEN_TESTPATTERN_EN to add tp_sel and the 8-bar colour test pattern.
//
// state    | meaning
// IDLE     | counters held at 0, no requests or syncs
// RUN      | raster counting, en high
// DRAIN    | en dropped; finish the current frame, then IDLE
module pocket_video_timing_gen
  import pocket_video_pkg::*;
#(
  parameter int H_ACTIVE     = pocket_video_pkg::H_ACTIVE_DEF,
  parameter int H_TOTAL      = pocket_video_pkg::H_TOTAL_DEF,
  parameter int H_HS_START   = pocket_video_pkg::H_HS_START_DEF,
  parameter int V_ACTIVE     = pocket_video_pkg::V_ACTIVE_DEF,
  parameter int V_TOTAL      = pocket_video_pkg::V_TOTAL_DEF,
  parameter int V_VS_LINE    = pocket_video_pkg::V_VS_LINE_DEF,
  parameter int READ_LATENCY = pocket_video_pkg::READ_LATENCY_DEF
) (
  input logic                        clk_vid,
  input logic                        reset_n,
  pocket_video_timing_gen_if.master  vid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0] state;
  logic [9:0] h;
  logic [9:0] v;
  logic       h_last;
  logic       v_last;
  logic       counting;
  logic       active;
  logic       hs_raw;
  logic       vs_raw;

  assign h_last   = (h == 10'(H_TOTAL - 1));
  assign v_last   = (v == 10'(V_TOTAL - 1));
  assign counting = (state != ST_IDLE);
  assign active   = counting && (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
  assign hs_raw   = counting && (h == 10'(H_HS_START));
  assign vs_raw   = hs_raw && (v == 10'(V_VS_LINE));

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          h <= '0;
          v <= '0;
          if (vid.en) state <= ST_RUN;
        end
        ST_RUN, ST_DRAIN: begin
          h <= h_last ? 10'd0 : h + 10'd1;
          if (h_last) v <= v_last ? 10'd0 : v + 10'd1;
          // Only a DRAIN that reaches the last pixel ends; frames are never cut short.
          if (vid.en)                                  state <= ST_RUN;
          else if (state == ST_DRAIN && h_last && v_last) state <= ST_IDLE;
          else                                         state <= ST_DRAIN;
        end
        default: begin
          state <= ST_IDLE;
          h     <= '0;
          v     <= '0;
        end
      endcase
    end
  end

  logic       px_req_q;
  logic [8:0] px_x_q;
  logic [8:0] px_y_q;
  logic       frame_start_q;

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      px_req_q      <= 1'b0;
      px_x_q        <= '0;
      px_y_q        <= '0;
      frame_start_q <= 1'b0;
    end else begin
      px_req_q      <= active;
      frame_start_q <= counting && (h == 10'd0) && (v == 10'd0);
      if (active) begin
        px_x_q <= h[8:0];
        px_y_q <= v[8:0];
      end
    end
  end

  // Stage 0 -> de_d takes READ_LATENCY+1 cycles so de_d lines up with px_data.
  logic [2:0] sync_d;

  pocket_video_delay #(.DEPTH(READ_LATENCY + 1), .WIDTH(3)) u_sync_delay (
    .clk_vid (clk_vid),
    .reset_n (reset_n),
    .din     ({active, hs_raw, vs_raw}),
    .dout    (sync_d)
  );

  rgb888_t pixel;

`ifdef VIDGEN_TESTPATTERN_EN
  logic [8:0] x_d;

  pocket_video_delay #(.DEPTH(READ_LATENCY), .WIDTH(9)) u_x_delay (
    .clk_vid (clk_vid),
    .reset_n (reset_n),
    .din     (px_x_q),
    .dout    (x_d)
  );

  assign pixel = vid.tp_sel ? bar_colour(x_d) : vid.px_data;
`else
  assign pixel = vid.px_data;
`endif

  logic    vid_de_q;
  logic    vid_hs_q;
  logic    vid_vs_q;
  rgb888_t vid_rgb_q;

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      vid_de_q  <= 1'b0;
      vid_hs_q  <= 1'b0;
      vid_vs_q  <= 1'b0;
      vid_rgb_q <= '0;
    end else begin
      vid_de_q  <= sync_d[2];
      vid_hs_q  <= sync_d[1];
      vid_vs_q  <= sync_d[0];
      vid_rgb_q <= sync_d[2] ? pixel : 24'h000000;
    end
  end

  assign vid.px_req      = px_req_q;
  assign vid.px_x        = px_x_q;
  assign vid.px_y        = px_y_q;
  assign vid.frame_start = frame_start_q;
  assign vid.busy        = counting;
  assign vid.vid_de      = vid_de_q;
  assign vid.vid_hs      = vid_hs_q;
  assign vid.vid_vs      = vid_vs_q;
  assign vid.vid_rgb     = vid_rgb_q;

endmodule

// File: tb/tb_pocket_video_timing_gen.sv
// Bench for pocket_video_timing_gen: two instances (read latency 2 and 5) on a reduced raster,
// checked cycle by cycle against a scoreboard plus frame-level counts.
module tb_pocket_video_timing_gen;
  import pocket_video_pkg::*;

  localparam int HA = 40, HT = 56, HS = 45, VA = 36, VT = 42, VV = 38;
  localparam int FRAME = HT * VT;
  localparam int RL_A = 2, RL_B = 5;
  localparam int LAT_A = RL_A + 2, LAT_B = RL_B + 2;

  logic clk_vid = 1'b0;
  logic reset_n = 1'b0;
  logic en_drv  = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk_vid = ~clk_vid;

  pocket_video_timing_gen_if if_a ();
  pocket_video_timing_gen_if if_b ();

  assign if_a.en = en_drv;
  assign if_b.en = en_drv;

  pocket_video_timing_gen #(.H_ACTIVE(HA), .H_TOTAL(HT), .H_HS_START(HS), .V_ACTIVE(VA),
    .V_TOTAL(VT), .V_VS_LINE(VV), .READ_LATENCY(RL_A)) u_a (
    .clk_vid (clk_vid), .reset_n (reset_n), .vid (if_a));

  pocket_video_timing_gen #(.H_ACTIVE(HA), .H_TOTAL(HT), .H_HS_START(HS), .V_ACTIVE(VA),
    .V_TOTAL(VT), .V_VS_LINE(VV), .READ_LATENCY(RL_B)) u_b (
    .clk_vid (clk_vid), .reset_n (reset_n), .vid (if_b));

  function automatic rgb888_t pix(input logic [9:0] x, input logic [9:0] y);
    return {x[7:0], y[7:0], x[7:0] ^ y[7:0] ^ 8'hA5};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Framebuffer reader model: returns pix() READ_LATENCY cycles after each px_req.
  logic [18:0] pipe_a [RL_A];
  logic [18:0] pipe_b [RL_B];

  always @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RL_A; i++) pipe_a[i] <= '0;
      for (int i = 0; i < RL_B; i++) pipe_b[i] <= '0;
    end else begin
      pipe_a[0] <= {if_a.px_req, if_a.px_x, if_a.px_y};
      pipe_b[0] <= {if_b.px_req, if_b.px_x, if_b.px_y};
      for (int i = 1; i < RL_A; i++) pipe_a[i] <= pipe_a[i-1];
      for (int i = 1; i < RL_B; i++) pipe_b[i] <= pipe_b[i-1];
    end
  end

  assign if_a.px_data = pipe_a[RL_A-1][18] ?
    pix({1'b0, pipe_a[RL_A-1][17:9]}, {1'b0, pipe_a[RL_A-1][8:0]}) : 24'h0F0F0F;
  assign if_b.px_data = pipe_b[RL_B-1][18] ?
    pix({1'b0, pipe_b[RL_B-1][17:9]}, {1'b0, pipe_b[RL_B-1][8:0]}) : 24'h0F0F0F;

  // Reference raster position: 0 idle, 1 run, 2 drain.
  int m_state, m_h, m_v;

  always @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      m_state <= 0; m_h <= 0; m_v <= 0;
    end else if (m_state == 0) begin
      if (en_drv) m_state <= 1;
    end else begin
      m_h <= (m_h == HT - 1) ? 0 : m_h + 1;
      if (m_h == HT - 1) m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
      if (en_drv) m_state <= 1;
      else if (m_state == 2 && m_h == HT - 1 && m_v == VT - 1) m_state <= 0;
      else m_state <= 2;
    end
  end

  typedef struct packed {logic de; logic hs; logic vs; logic [23:0] rgb;} vexp_t;
  typedef struct packed {logic req; logic [8:0] x; logic [8:0] y; logic fs;} sexp_t;

  vexp_t      qa[$], qb[$];
  sexp_t      qs[$];
  logic [8:0] lx, ly;

  always @(negedge clk_vid) begin
    if (!reset_n) begin
      qa.delete(); qb.delete(); qs.delete();
      repeat (LAT_A) qa.push_back('0);
      repeat (LAT_B) qb.push_back('0);
      qs.push_back('0);
      lx = '0; ly = '0;
    end else begin
      logic  run, act, hsx;
      vexp_t ev, ea, eb;
      sexp_t es;
      run = (m_state != 0);
      act = run && m_h < HA && m_v < VA;
      hsx = run && m_h == HS;
      ev  = '{de: act, hs: hsx, vs: hsx && m_v == VV, rgb: act ? pix(10'(m_h), 10'(m_v)) : 24'h0};
      if (act) begin lx = 9'(m_h); ly = 9'(m_v); end
      qa.push_back(ev); qb.push_back(ev);
      qs.push_back('{req: act, x: lx, y: ly, fs: run && m_h == 0 && m_v == 0});
      ea = qa.pop_front(); eb = qb.pop_front(); es = qs.pop_front();
      chk("vid_a", 64'({if_a.vid_de, if_a.vid_hs, if_a.vid_vs, if_a.vid_rgb}), 64'(ea));
      chk("vid_b", 64'({if_b.vid_de, if_b.vid_hs, if_b.vid_vs, if_b.vid_rgb}), 64'(eb));
      chk("fetch_a", 64'({if_a.px_req, if_a.px_x, if_a.px_y, if_a.frame_start}), 64'(es));
      chk("fetch_b", 64'({if_b.px_req, if_b.px_x, if_b.px_y, if_b.frame_start}), 64'(es));
      chk("busy_a", 64'(if_a.busy), 64'(run));
      chk("busy_b", 64'(if_b.busy), 64'(run));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_vid);
    #1;
  endtask

  task automatic wait_pos(input int hh, input int vv);
    int n = 0;
    while (!(m_state != 0 && m_h == hh && m_v == vv) && n < 2 * FRAME) begin
      step(1); n++;
    end
    chk("wait_pos_timeout", 64'(n < 2 * FRAME), 64'd1);
  endtask

  task automatic wait_fs();
    int n = 0;
    while (!if_a.frame_start && n < 2 * FRAME) begin
      step(1); n++;
    end
    chk("frame_start_timeout", 64'(if_a.frame_start), 64'd1);
  endtask

  initial begin
    int n, fa, fb, de_c, hs_c, vs_c, fs_c, last_hs;
`ifdef VIDGEN_TESTPATTERN_EN
    if_a.tp_sel = 1'b0;
    if_b.tp_sel = 1'b0;
`endif
    step(5);
    reset_n = 1'b1;
    step(3);
    chk("reset_outputs_a", 64'({if_a.px_req, if_a.px_x, if_a.px_y, if_a.vid_de, if_a.vid_hs,
        if_a.vid_vs, if_a.vid_rgb, if_a.frame_start, if_a.busy}), 64'd0);

    // First DE lands READ_LATENCY+2 cycles after the first counted cycle.
    en_drv = 1'b1;
    n = 0; fa = 0; fb = 0;
    while ((fa == 0 || fb == 0) && n < 40) begin
      step(1); n++;
      if (fa == 0 && if_a.vid_de) fa = n;
      if (fb == 0 && if_b.vid_de) fb = n;
    end
    chk("first_de_a", 64'(fa), 64'(LAT_A + 1));
    chk("first_de_b", 64'(fb), 64'(LAT_B + 1));

    // Two full frames of aggregate counts.
    wait_fs();
    for (int f = 0; f < 2; f++) begin
      de_c = 0; hs_c = 0; vs_c = 0; fs_c = 0; last_hs = 0;
      for (int k = 1; k <= FRAME; k++) begin
        step(1);
        if (if_a.vid_de) de_c++;
        if (if_a.vid_vs) begin
          vs_c++;
          chk("vs_on_hs", 64'(if_a.vid_hs), 64'd1);
        end
        if (if_a.vid_hs) begin
          if (last_hs != 0) chk("hs_spacing", 64'(k - last_hs), 64'(HT));
          last_hs = k; hs_c++;
        end
        if (k < FRAME && if_a.frame_start) fs_c++;
      end
      chk("frame_start_period", 64'(if_a.frame_start), 64'd1);
      chk("early_frame_start", 64'(fs_c), 64'd0);
      chk("de_count", 64'(de_c), 64'(HA * VA));
      chk("hs_count", 64'(hs_c), 64'(VT));
      chk("vs_count", 64'(vs_c), 64'd1);
    end

    // One-cycle en drop mid-frame: raster must be undisturbed.
    wait_pos(13, 7);
    en_drv = 1'b0;
    step(1);
    en_drv = 1'b1;
    wait_fs();
    step(FRAME);
    chk("glitch_frame_period", 64'(if_a.frame_start), 64'd1);

    // Stop at line 10: drains to the end of the frame then idles.
    wait_pos(0, 10);
    en_drv = 1'b0;
    n = 0;
    while (if_a.busy && n < 2 * FRAME) begin
      step(1); n++;
    end
    chk("drain_length", 64'(n), 64'(FRAME - 10 * HT));
    de_c = 0;
    for (int k = 0; k < 2 * HT; k++) begin
      step(1);
      if (if_a.px_req || if_a.vid_de || if_a.vid_hs || if_b.px_req || if_b.vid_de || if_b.vid_hs)
        de_c++;
    end
    chk("idle_quiet", 64'(de_c), 64'd0);

    // Reset mid-frame at h=20, v=5.
    en_drv = 1'b1;
    wait_pos(20, 5);
    reset_n = 1'b0;
    #1;
    chk("async_reset_a", 64'({if_a.px_req, if_a.px_x, if_a.px_y, if_a.vid_de, if_a.vid_hs,
        if_a.vid_vs, if_a.vid_rgb, if_a.frame_start, if_a.busy}), 64'd0);
    chk("async_reset_b", 64'({if_b.px_req, if_b.px_x, if_b.px_y, if_b.vid_de, if_b.vid_hs,
        if_b.vid_vs, if_b.vid_rgb, if_b.frame_start, if_b.busy}), 64'd0);
    step(3);
    reset_n = 1'b1;
    step(2);
    chk("restart_frame_start", 64'(if_a.frame_start), 64'd1);
    step(FRAME + 20);

    en_drv = 1'b0;
    step(2 * FRAME);
    chk("final_idle", 64'(if_a.busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
